// File: rtl/pix_pack_16to256.sv
// rtl/pix_pack_16to256.sv - packs 16-bit pixel words into 256-bit FIFO write words
// First pixel lands in the low lane; in_last flushes a zero-padded partial word.
module pix_pack_16to256 #(
    parameter int IN_WIDTH  = 16,
    parameter int OUT_WIDTH = 256
) (
    input  logic                 wr_clk,
    input  logic                 wr_rst,
    input  logic                 in_valid,
    input  logic [IN_WIDTH-1:0]  in_data,
    input  logic                 in_last,
    output logic                 in_ready,
    output logic                 out_wr_en,
    output logic [OUT_WIDTH-1:0] out_wr_data,
    input  logic                 out_full,
    output logic [15:0]          line_words,
    output logic                 busy
);
    localparam int LANES  = OUT_WIDTH / IN_WIDTH;
    localparam int LANE_W = $clog2(LANES);

    logic [LANE_W-1:0]    r_idx;
    logic [OUT_WIDTH-1:0] r_acc;
    logic                 r_hold_valid;
    logic [OUT_WIDTH-1:0] r_hold_data;
    logic                 r_hold_last;
    logic [15:0]          r_line_words;
    logic [15:0]          r_wcnt;

    logic                 w_accept;
    logic                 w_complete;
    logic                 w_drain;
    logic [OUT_WIDTH-1:0] w_merged;

    assign in_ready    = !r_hold_valid || !out_full;
    assign w_accept    = in_valid && in_ready;
    assign w_complete  = w_accept && ((r_idx == LANE_W'(LANES - 1)) || in_last);
    assign w_drain     = r_hold_valid && !out_full;
    assign out_wr_en   = w_drain;
    assign out_wr_data = r_hold_data;
    assign line_words  = r_line_words;
    assign busy        = (r_idx != '0) || r_hold_valid;

    // Accumulator with the incoming lane merged in; lanes above idx are forced to zero.
    always_comb begin
        w_merged = '0;
        for (int l = 0; l < LANES; l++) begin
            if (LANE_W'(l) < r_idx)
                w_merged[l*IN_WIDTH +: IN_WIDTH] = r_acc[l*IN_WIDTH +: IN_WIDTH];
            else if (LANE_W'(l) == r_idx)
                w_merged[l*IN_WIDTH +: IN_WIDTH] = in_data;
        end
    end

    always_ff @(posedge wr_clk) begin
        if (wr_rst) begin
            r_idx        <= '0;
            r_acc        <= '0;
            r_hold_valid <= 1'b0;
            r_hold_data  <= '0;
            r_hold_last  <= 1'b0;
            r_line_words <= '0;
            r_wcnt       <= '0;
        end else begin
            if (w_accept) begin
                if (w_complete) begin
                    r_idx <= '0;
                    r_acc <= '0;
                end else begin
                    r_idx <= r_idx + LANE_W'(1);
                    r_acc <= w_merged;
                end
            end

            // A new word may load into the hold register in the same cycle it drains.
            if (w_complete) begin
                r_hold_valid <= 1'b1;
                r_hold_data  <= w_merged;
                r_hold_last  <= in_last;
            end else if (w_drain) begin
                r_hold_valid <= 1'b0;
            end

            if (w_drain) begin
                if (r_hold_last) begin
                    r_line_words <= (r_wcnt == 16'hFFFF) ? 16'hFFFF : r_wcnt + 16'd1;
                    r_wcnt       <= '0;
                end else if (r_wcnt != 16'hFFFF) begin
                    r_wcnt <= r_wcnt + 16'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_pix_pack_16to256.sv
// tb/tb_pix_pack_16to256.sv - scoreboard bench for pix_pack_16to256
module tb_pix_pack_16to256;
    logic         wr_clk = 1'b0;
    logic         wr_rst = 1'b1;
    logic         in_valid = 1'b0;
    logic [15:0]  in_data = '0;
    logic         in_last = 1'b0;
    logic         in_ready;
    logic         out_wr_en;
    logic [255:0] out_wr_data;
    logic         out_full = 1'b0;
    logic [15:0]  line_words;
    logic         busy;

    pix_pack_16to256 dut (
        .wr_clk(wr_clk), .wr_rst(wr_rst), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .in_ready(in_ready), .out_wr_en(out_wr_en),
        .out_wr_data(out_wr_data), .out_full(out_full), .line_words(line_words), .busy(busy)
    );

    always #5 wr_clk = ~wr_clk;

    typedef struct {
        logic [255:0] data;
        logic         last;
        logic [15:0]  lw;
    } exp_t;

    exp_t         q[$];
    int           n_vec = 0;
    int           n_err = 0;
    int           n_writes = 0;
    int           m_idx = 0;
    logic [255:0] m_acc = '0;
    int           m_wpl = 0;
    bit           rnd_run = 0;

    task automatic model_accept(input logic [15:0] d, input bit last);
        exp_t e;
        m_acc[m_idx*16 +: 16] = d;
        if (m_idx == 15 || last) begin
            m_wpl++;
            e.data = m_acc;
            e.last = last;
            e.lw   = 16'(m_wpl);
            q.push_back(e);
            if (last) m_wpl = 0;
            m_idx = 0;
            m_acc = '0;
        end else begin
            m_idx++;
        end
    endtask

    // Write monitor: every FIFO write is popped against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge wr_clk);
            if (out_wr_en === 1'b1) begin
                n_writes++;
                n_vec++;
                if (q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_write data=%h", out_wr_data);
                end else begin
                    e = q.pop_front();
                    if (out_wr_data !== e.data) begin
                        n_err++;
                        $display("FAIL write_data got=%h exp=%h", out_wr_data, e.data);
                    end
                    if (e.last) begin
                        @(posedge wr_clk);
                        #1;
                        n_vec++;
                        if (line_words !== e.lw) begin
                            n_err++;
                            $display("FAIL line_words got=%0d exp=%0d", line_words, e.lw);
                        end
                    end
                end
            end
        end
    end

    task automatic do_reset();
        wr_rst   = 1'b1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (2) @(posedge wr_clk);
        #1;
        wr_rst = 1'b0;
        m_idx  = 0;
        m_acc  = '0;
        m_wpl  = 0;
        q.delete();
    endtask

    task automatic send_word(input logic [15:0] d, input bit last);
        bit ok;
        bit got;
        got      = 0;
        in_data  = d;
        in_last  = last;
        in_valid = 1'b1;
        for (int c = 0; c < 200 && !got; c++) begin
            @(negedge wr_clk);
            ok = in_ready;
            @(posedge wr_clk);
            if (ok) begin
                got = 1;
                model_accept(d, last);
            end
        end
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        n_vec++;
        if (!got) begin
            n_err++;
            $display("FAIL send_word_timeout got=not_accepted exp=accepted data=%h", d);
        end
    endtask

    task automatic wait_drain();
        for (int c = 0; c < 500 && q.size() != 0; c++) @(posedge wr_clk);
        repeat (2) @(posedge wr_clk);
        #1;
        n_vec++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain got=%0d_pending exp=0", q.size());
        end
    endtask

    task automatic test_reset();
        wr_rst = 1'b1;
        repeat (2) @(posedge wr_clk);
        @(negedge wr_clk);
        n_vec++;
        if ({out_wr_en, in_ready, busy} !== 3'b010) begin
            n_err++;
            $display("FAIL reset_flags got=%b exp=010", {out_wr_en, in_ready, busy});
        end
        n_vec++;
        if (out_wr_data !== '0 || line_words !== 16'd0) begin
            n_err++;
            $display("FAIL reset_data got=%h/%0d exp=0/0", out_wr_data, line_words);
        end
        do_reset();
    endtask

    task automatic test_full_word();
        int base;
        do_reset();
        base = n_writes;
        for (int i = 1; i <= 16; i++) send_word(16'(i), 0);
        @(negedge wr_clk);
        n_vec++;
        if (out_wr_en !== 1'b1 || out_wr_data[15:0] !== 16'h0001 || out_wr_data[255:240] !== 16'h0010) begin
            n_err++;
            $display("FAIL full_word_latency got=%b/%h/%h exp=1/0001/0010",
                     out_wr_en, out_wr_data[15:0], out_wr_data[255:240]);
        end
        @(posedge wr_clk);
        #1;
        n_vec++;
        if (busy !== 1'b0 || n_writes - base != 1) begin
            n_err++;
            $display("FAIL full_word_done got=busy%b/writes%0d exp=busy0/writes1", busy, n_writes - base);
        end
    endtask

    task automatic test_partial();
        do_reset();
        for (int i = 0; i < 5; i++) send_word(16'hA000 + 16'(i), i == 4);
        @(negedge wr_clk);
        n_vec++;
        if (out_wr_en !== 1'b1 || out_wr_data[255:80] !== '0 || out_wr_data[79:64] !== 16'hA004) begin
            n_err++;
            $display("FAIL partial_word got=%b/%h exp=1/zero-padded-A004", out_wr_en, out_wr_data);
        end
        @(posedge wr_clk);
        #1;
        n_vec++;
        if (line_words !== 16'd1) begin
            n_err++;
            $display("FAIL partial_line_words got=%0d exp=1", line_words);
        end
    endtask

    task automatic test_multi_line();
        int base;
        base = n_writes;
        for (int i = 0; i < 40; i++) send_word(16'h4000 + 16'(i), i == 39);
        wait_drain();
        n_vec++;
        if (n_writes - base != 3 || line_words !== 16'd3) begin
            n_err++;
            $display("FAIL multi_line got=writes%0d/lw%0d exp=writes3/lw3", n_writes - base, line_words);
        end
        for (int i = 0; i < 3; i++) send_word(16'h7700 + 16'(i), i == 2);
        send_word(16'h5A5A, 1);
        wait_drain();
        n_vec++;
        if (line_words !== 16'd1) begin
            n_err++;
            $display("FAIL lane0_last got=%0d exp=1", line_words);
        end
    endtask

    task automatic test_backpressure();
        int base;
        base     = n_writes;
        out_full = 1'b1;
        for (int i = 0; i < 16; i++) send_word(16'hC000 + 16'(i), 0);
        @(negedge wr_clk);
        n_vec++;
        if (in_ready !== 1'b0 || busy !== 1'b1 || out_wr_en !== 1'b0) begin
            n_err++;
            $display("FAIL bp_stall got=rdy%b/busy%b/wr%b exp=rdy0/busy1/wr0", in_ready, busy, out_wr_en);
        end
        repeat (4) @(posedge wr_clk);
        #1;
        n_vec++;
        if (n_writes != base) begin
            n_err++;
            $display("FAIL bp_no_write got=%0d exp=0", n_writes - base);
        end
        out_full = 1'b0;
        for (int i = 0; i < 16; i++) send_word(16'hD000 + 16'(i), 0);
        wait_drain();
        n_vec++;
        if (n_writes - base != 2) begin
            n_err++;
            $display("FAIL bp_release got=%0d exp=2", n_writes - base);
        end
    endtask

    task automatic test_reset_midline();
        int base;
        base = n_writes;
        for (int i = 0; i < 7; i++) send_word(16'hE000 + 16'(i), 0);
        wr_rst = 1'b1;
        @(posedge wr_clk);
        @(negedge wr_clk);
        n_vec++;
        if ({out_wr_en, in_ready, busy} !== 3'b010 || out_wr_data !== '0) begin
            n_err++;
            $display("FAIL midline_reset got=%b/%h exp=010/0", {out_wr_en, in_ready, busy}, out_wr_data);
        end
        do_reset();
        for (int i = 0; i < 16; i++) send_word(16'hB000 + 16'(i), 0);
        wait_drain();
        n_vec++;
        if (n_writes - base != 1) begin
            n_err++;
            $display("FAIL midline_after got=%0d exp=1", n_writes - base);
        end
    endtask

    task automatic test_random();
        do_reset();
        rnd_run = 1;
        fork
            while (rnd_run) begin
                @(posedge wr_clk);
                #1;
                out_full = ($urandom_range(0, 3) == 0);
            end
        join_none
        for (int k = 0; k < 10000; k++) begin
            while ($urandom_range(0, 3) == 0) begin
                @(posedge wr_clk);
                #1;
            end
            send_word(16'($urandom), (k % 53 == 52) || (k == 9999));
        end
        rnd_run = 0;
        @(posedge wr_clk);
        #2;
        out_full = 1'b0;
        wait_drain();
    endtask

    initial begin
        test_reset();
        test_full_word();
        test_partial();
        test_multi_line();
        test_backpressure();
        test_reset_midline();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
